// File: rtl/sdram_aref_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_aref_if
//  Description : Arbiter-side bundle for the SDRAM auto-refresh generator:
//                init status, grant/request handshake and the command bus.
//  Revision    : 1.0  initial release
// ============================================================================
interface sdram_aref_if;
  logic        init_end;
  logic        aref_en;
  logic        aref_req;
  logic [3:0]  aref_cmd;
  logic [1:0]  aref_bank;
  logic [12:0] aref_addr;
  logic        aref_end;

  // Arbiter / controller side
  modport master (
    output init_end,
    output aref_en,
    input  aref_req,
    input  aref_cmd,
    input  aref_bank,
    input  aref_addr,
    input  aref_end
  );

  // Refresh generator side
  modport slave (
    input  init_end,
    input  aref_en,
    output aref_req,
    output aref_cmd,
    output aref_bank,
    output aref_addr,
    output aref_end
  );
endinterface
`default_nettype wire

// File: rtl/sdram_aref.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_aref
//  Description : Periodic auto-refresh generator for the W9825G6KH SDRAM.
//                Counts the refresh interval once init is done, requests the
//                bus, and on grant issues PRECHARGE-ALL followed by AREF_NUM
//                AUTO REFRESH commands with tRP / tRFC spacing.
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_aref #(
  parameter int CNT_REF_MAX = 750,
  parameter int TRP         = 2,
  parameter int TRF         = 7,
  parameter int AREF_NUM    = 2
) (
  input  wire logic   clk,
  input  wire logic   rstn,
  sdram_aref_if.slave bus
);

  localparam logic [3:0]  c_CMD_NOP  = 4'b0111;
  localparam logic [3:0]  c_CMD_PRE  = 4'b0010;
  localparam logic [3:0]  c_CMD_AREF = 4'b0001;
  localparam logic [1:0]  c_BANK     = 2'b11;
  localparam logic [12:0] c_ADDR     = 13'h1fff;  // A10=1 -> precharge all banks

  localparam logic [9:0]  c_REF_LAST = 10'(CNT_REF_MAX - 1);
  localparam logic [2:0]  c_TRP_LAST = 3'(TRP - 1);
  localparam logic [2:0]  c_TRF_LAST = 3'(TRF - 1);
  localparam logic [2:0]  c_AREF_NUM = 3'(AREF_NUM);

  typedef enum logic [2:0] {
    AREF_IDLE = 3'd0,
    AREF_PCHA = 3'd1,
    AREF_TRP  = 3'd2,
    AREF_AR   = 3'd3,
    AREF_TRF  = 3'd4,
    AREF_END  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_cnt_ref;
  logic [2:0]  r_cnt_clk;
  logic [2:0]  r_cnt_aref;
  logic        r_req;
  logic [3:0]  r_cmd;
  logic [1:0]  r_bank;
  logic [12:0] r_addr;
  logic        w_ref_tick;
  logic        w_accept;
  logic        w_state_chg;

  assign w_ref_tick  = bus.init_end && (r_cnt_ref == c_REF_LAST);
  assign w_accept    = (r_state == AREF_IDLE) && bus.aref_en && bus.init_end;
  assign w_state_chg = (w_state_nxt != r_state);

  // Refresh interval counter: free-runs only while init is complete
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                r_cnt_ref <= '0;
    else if (!bus.init_end)   r_cnt_ref <= '0;
    else if (w_ref_tick)      r_cnt_ref <= '0;
    else                      r_cnt_ref <= r_cnt_ref + 10'd1;
  end

  // Request flag: acceptance wins over a coincident tick; ticks merge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                r_req <= 1'b0;
    else if (!bus.init_end)   r_req <= 1'b0;
    else if (w_accept)        r_req <= 1'b0;
    else if (w_ref_tick)      r_req <= 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= AREF_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode of the precharge / refresh sequence
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      AREF_IDLE: if (bus.aref_en && bus.init_end) w_state_nxt = AREF_PCHA;
      AREF_PCHA: w_state_nxt = AREF_TRP;
      AREF_TRP:  if (r_cnt_clk == c_TRP_LAST) w_state_nxt = AREF_AR;
      AREF_AR:   w_state_nxt = AREF_TRF;
      AREF_TRF:  if (r_cnt_clk == c_TRF_LAST)
                   w_state_nxt = (r_cnt_aref == c_AREF_NUM) ? AREF_END : AREF_AR;
      AREF_END:  w_state_nxt = AREF_IDLE;
      default:   w_state_nxt = AREF_IDLE;
    endcase
  end

  // Wait-cycle counter, restarted at every state boundary
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_cnt_clk <= '0;
    else if (w_state_chg || r_state == AREF_IDLE || r_state == AREF_END)
      r_cnt_clk <= '0;
    else if (r_state == AREF_TRP || r_state == AREF_TRF)
      r_cnt_clk <= r_cnt_clk + 3'd1;
  end

  // Number of AUTO REFRESH commands issued in the current sequence
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      r_cnt_aref <= '0;
    else if (r_state == AREF_IDLE)  r_cnt_aref <= '0;
    else if (r_state == AREF_AR)    r_cnt_aref <= r_cnt_aref + 3'd1;
  end

  // Registered command bus, one cycle behind the issuing state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cmd  <= c_CMD_NOP;
      r_bank <= c_BANK;
      r_addr <= c_ADDR;
    end else begin
      r_bank <= c_BANK;
      r_addr <= c_ADDR;
      case (r_state)
        AREF_PCHA: r_cmd <= c_CMD_PRE;
        AREF_AR:   r_cmd <= c_CMD_AREF;
        default:   r_cmd <= c_CMD_NOP;
      endcase
    end
  end

  assign bus.aref_req  = r_req;
  assign bus.aref_cmd  = r_cmd;
  assign bus.aref_bank = r_bank;
  assign bus.aref_addr = r_addr;
  assign bus.aref_end  = (r_state == AREF_END);

endmodule
`default_nettype wire
